tdpram: RTL
===========

TDPRAM -- requirements
Module: tdpram

Interface
REQ-001 SHALL have parameter DW, default 16: data width in bits, a multiple of 8, range 8..64.
REQ-002 SHALL have parameter AW, default 10: address width; depth = 2**AW words.
REQ-003 SHALL have parameter RDW, default 0: same-port read-during-write; 0 = old data, 1 = new merged data.
REQ-004 SHALL have parameter INIT, default 0: DW-bit fill value written by the clear engine.
REQ-005 SHALL have clock, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have reset_n, input, 1: reset; synchronous, active-low.
REQ-007 SHALL have clr, input, 1: one-cycle request to start a memory clear.
REQ-008 SHALL have busy, output, 1: high while the clear engine owns the array.
REQ-009 SHALL have ce1/ce2, input, 1: port 1/2 enable.
REQ-010 SHALL have we1/we2, input, DW/8: port 1/2 byte write enables; bit i covers data bits 8i+7..8i.
REQ-011 SHALL have a1/a2, input, AW: port 1/2 word address.
REQ-012 SHALL have di1/di2, input, DW: port 1/2 write data.
REQ-013 SHALL have do1/do2, output, DW: port 1/2 registered read data.

Function
REQ-014 SHALL provide two fully independent read/write ports on one shared array of 2**AW x DW.
REQ-015 SHALL perform a read when ce=1 and we=0; do updates at the next rising edge (latency 1).
REQ-016 SHALL write only the bytes whose we bit is 1 when ce=1; other bytes keep their value.
REQ-017 SHALL, on a write cycle, load do with the pre-write word when RDW=0, or with the post-write merged word when RDW=1.
REQ-018 SHALL hold do unchanged when ce=0.
REQ-019 SHALL, when both ports write the same address in one cycle, resolve per byte: port 1 wins bytes both enable; each port's other enabled bytes are written.
REQ-020 SHALL, when one port reads an address the other port writes in the same cycle, return the old data.
REQ-021 SHALL implement an FSM with two states: IDLE (busy=0) and CLEAR (busy=1).
REQ-022 SHALL move from IDLE to CLEAR on clr=1 and load the clear counter with 0.
REQ-023 SHALL, in CLEAR, write INIT to the counter address every cycle and then increment the counter.
REQ-024 SHALL return from CLEAR to IDLE at the edge that writes address 2**AW-1, giving busy high for exactly 2**AW cycles.
REQ-025 SHALL ignore clr while busy=1.
REQ-026 SHALL ignore all ce/we port accesses while busy=1; do1/do2 hold their values during this time.

Reset
REQ-027 SHALL, on any edge with reset_n=0, force do1=0, do2=0, and counter=0; array contents are not altered by reset itself.
REQ-028 SHALL, on reset during CLEAR, abort the clear and restart it from address 0 under the rules of REQ-029/REQ-030.
REQ-029 SHALL hold busy=1 while reset_n=0 when TDPRAM_AUTOCLR_EN is defined, and busy=0 otherwise.

Configuration
REQ-030 SHALL, with macro TDPRAM_AUTOCLR_EN defined, enter CLEAR from reset: the first edge with reset_n=1 writes address 0, and busy falls after 2**AW cycles.
REQ-031 SHALL, without TDPRAM_AUTOCLR_EN, enter IDLE from reset with undefined array contents; clearing occurs only through clr.

Verification (DW=16, AW=4, INIT=16'h0000)
REQ-032 SHALL cover: with AUTOCLR, release reset -> busy=1 for exactly 16 cycles; then read of every address returns 16'h0000.
REQ-033 SHALL cover: p1 writes 16'hABCD to a1=3 with we1=2'b11, then we1=2'b01 with di1=16'h0012 -> later read of a1=3 returns 16'hAB12.
REQ-034 SHALL cover: with RDW=0 and then RDW=1, write 16'h5555 over 16'h1234 at address 7 -> do1 returns 16'h1234 and 16'h5555 respectively in the next cycle.
REQ-035 SHALL cover: same cycle, p1 writes 16'h1111 (we=2'b01) and p2 writes 16'h2222 (we=2'b11) to address 5 -> address 5 reads 16'h2211.
REQ-036 SHALL cover: assert clr, then reset_n=0 at clear cycle 8 -> busy restarts; a full 16-cycle clear follows, and p1 writes issued during busy are not stored.
REQ-037 SHALL cover: without AUTOCLR, after reset busy=0; clr pulse -> busy=1 for 16 cycles; a second clr during busy does not extend it.

Source files
------------

// File: rtl/tdpram.sv
// True dual-port RAM with byte write enables and a built-in clear engine.
// Both ports share one 2**AW x DW array; port 1 wins bytes that both ports
// write at the same address in the same cycle. The clear engine sweeps the
// array with INIT one word per cycle and locks out both ports while busy.
// Optional feature macro: TDPRAM_AUTOCLR_EN -- when defined, reset leaves the
// engine in CLEAR so the array is swept automatically after reset release.
module tdpram #(
  parameter int            DW   = 16,
  parameter int            AW   = 10,
  parameter int            RDW  = 0,
  parameter logic [DW-1:0] INIT = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clr,
  output logic            busy,
  input  logic            ce1,
  input  logic [DW/8-1:0] we1,
  input  logic [AW-1:0]   a1,
  input  logic [DW-1:0]   di1,
  output logic [DW-1:0]   do1,
  input  logic            ce2,
  input  logic [DW/8-1:0] we2,
  input  logic [AW-1:0]   a2,
  input  logic [DW-1:0]   di2,
  output logic [DW-1:0]   do2
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, CLEAR} state_t;

`ifdef TDPRAM_AUTOCLR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  logic [DW-1:0]   mem_q [DEPTH];
  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   do1_q, do1_d;
  logic [DW-1:0]   do2_q, do2_d;
  logic            acc1, acc2;
  logic            clr_wr;
  logic [NB-1:0]   wm1, wm2;
  logic [DW-1:0]   post1, post2;

  assign busy   = (state_q == CLEAR);
  assign acc1   = ce1 && !busy && reset_n;
  assign acc2   = ce2 && !busy && reset_n;
  assign wm1    = acc1 ? we1 : '0;
  assign wm2    = acc2 ? we2 : '0;
  // Reset itself never touches the array, even when it parks the engine in CLEAR.
  assign clr_wr = busy && reset_n;
  assign do1    = do1_q;
  assign do2    = do2_q;

  // Clear-engine next state: start on clr from IDLE, sweep one word per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear-engine state and counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Post-write word seen at each port's address, with port 1 owning shared bytes.
  always_comb begin
    post1 = mem_q[a1];
    post2 = mem_q[a2];
    for (int b = 0; b < NB; b++) begin
      if (wm1[b])
        post1[8*b +: 8] = di1[8*b +: 8];
      else if (wm2[b] && (a2 == a1))
        post1[8*b +: 8] = di2[8*b +: 8];
      if (wm1[b] && (a1 == a2))
        post2[8*b +: 8] = di1[8*b +: 8];
      else if (wm2[b])
        post2[8*b +: 8] = di2[8*b +: 8];
    end
  end

  // Read data selection: old word, or merged word on a write when RDW=1.
  always_comb begin
    do1_d = mem_q[a1];
    do2_d = mem_q[a2];
    if ((RDW == 1) && (|wm1)) do1_d = post1;
    if ((RDW == 1) && (|wm2)) do2_d = post2;
  end

  // Registered read ports: cleared by reset, held when idle or locked out.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      do1_q <= '0;
      do2_q <= '0;
    end else begin
      if (acc1) do1_q <= do1_d;
      if (acc2) do2_q <= do2_d;
    end
  end

  // Array writes: clear sweep, then port 2 and port 1 bytes (port 1 last so it wins).
  always_ff @(posedge clock) begin
    if (clr_wr) mem_q[cnt_q] <= INIT;
    for (int b = 0; b < NB; b++) begin
      if (wm2[b]) mem_q[a2][8*b +: 8] <= di2[8*b +: 8];
      if (wm1[b]) mem_q[a1][8*b +: 8] <= di1[8*b +: 8];
    end
  end

endmodule
